// File: rtl/vga_text_buffer.sv
// Terminal-style character store feeding the VGA renderer: putchar with CR/LF/BS,
// cursor tracking, scroll by rotating a row base, and a 1-cycle registered read port.
module vga_text_buffer #(
    parameter  int h_disp          = 1280,
    parameter  int v_disp          = 1024,
    localparam int cols            = h_disp / 8,
    localparam int rows            = v_disp / 8,
    localparam int cells           = cols * rows,
    localparam int char_addr_width = $clog2(cells),
    localparam int col_w           = $clog2(cols),
    localparam int row_w           = $clog2(rows)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [char_addr_width-1:0] addr_read,
    output logic [7:0]                 char_read,
    input  logic [7:0]                 char_in,
    input  logic                       char_valid,
    output logic                       char_ready,
    input  logic                       clear,
    output logic [col_w-1:0]           cursor_x,
    output logic [row_w-1:0]           cursor_y,
    output logic                       busy
);

    localparam int AW = char_addr_width;
    localparam logic [AW-1:0]    CELLS_A  = AW'(cells);
    localparam logic [AW-1:0]    COLS_A   = AW'(cols);
    localparam logic [AW-1:0]    LAST_ROW = AW'(cells - cols);
    localparam logic [col_w-1:0] X_MAX    = col_w'(cols - 1);
    localparam logic [row_w-1:0] Y_MAX    = row_w'(rows - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;

    state_t            state;
    logic [col_w-1:0]  cur_x;
    logic [row_w-1:0]  cur_y;
    logic [AW-1:0]     base;
    logic [AW-1:0]     clr_ptr;
    logic [7:0]        ram [cells];

    logic              accept, printable, is_lf, is_cr, is_bs, newline;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [7:0]        wdata;
    logic [AW-1:0]     rd_phys;
    logic [AW-1:0]     base_next;

    // Logical -> physical: add the rotating base, wrapping once at the end of the store.
    function automatic logic [AW-1:0] to_phys(input logic [AW-1:0] logical,
                                              input logic [AW-1:0] off);
        logic [AW-1:0] room;
        room = CELLS_A - off;
        if (logical >= room)
            return logical - room;
        else
            return logical + off;
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [col_w-1:0] x,
                                                input logic [row_w-1:0] y);
        return AW'(y) * COLS_A + AW'(x);
    endfunction

    assign cursor_x  = cur_x;
    assign cursor_y  = cur_y;
    assign rd_phys   = to_phys(addr_read, base);
    assign base_next = (base == LAST_ROW) ? '0 : base + COLS_A;

    always_comb begin
        char_ready = (state == IDLE) && !clear;
        busy       = (state != IDLE);
        accept     = char_ready && char_valid;
        printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);
        is_lf      = (char_in == 8'h0A);
        is_cr      = (char_in == 8'h0D);
        is_bs      = (char_in == 8'h08);
        newline    = accept && (is_lf || (printable && cur_x == X_MAX));
        we         = 1'b0;
        waddr      = '0;
        wdata      = 8'h20;
        case (state)
            CLEAR: begin
                we    = 1'b1;
                waddr = clr_ptr;
            end
            SCROLL: begin
                we    = 1'b1;
                waddr = to_phys(LAST_ROW + clr_ptr, base);
            end
            default: begin
                if (accept) begin
                    if (printable) begin
                        we    = 1'b1;
                        waddr = to_phys(cell_addr(cur_x, cur_y), base);
                        wdata = char_in;
                    end else if (is_bs && cur_x != '0) begin
                        we    = 1'b1;
                        waddr = to_phys(cell_addr(cur_x - col_w'(1), cur_y), base);
                    end else if (is_bs && cur_y != '0) begin
                        we    = 1'b1;
                        waddr = to_phys(cell_addr(X_MAX, cur_y - row_w'(1)), base);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            cur_x   <= '0;
            cur_y   <= '0;
            base    <= '0;
            clr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state   <= CLEAR;
                        cur_x   <= '0;
                        cur_y   <= '0;
                        base    <= '0;
                        clr_ptr <= '0;
                    end else if (accept) begin
                        if (printable) begin
                            cur_x <= (cur_x == X_MAX) ? '0 : cur_x + col_w'(1);
                        end else if (is_cr) begin
                            cur_x <= '0;
                        end else if (is_bs) begin
                            if (cur_x != '0) begin
                                cur_x <= cur_x - col_w'(1);
                            end else if (cur_y != '0) begin
                                cur_x <= X_MAX;
                                cur_y <= cur_y - row_w'(1);
                            end
                        end
                        // Bottom-row newline scrolls: rotate base, then blank the new last row.
                        if (newline) begin
                            if (cur_y != Y_MAX) begin
                                cur_y <= cur_y + row_w'(1);
                            end else begin
                                base    <= base_next;
                                clr_ptr <= '0;
                                state   <= SCROLL;
                            end
                        end
                    end
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (clr_ptr == CELLS_A - AW'(1))
                        state <= IDLE;
                end
                SCROLL: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (clr_ptr == COLS_A - AW'(1))
                        state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            ram[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            char_read <= 8'h00;
        else
            char_read <= ram[rd_phys];
    end

endmodule

// File: tb/tb_vga_text_buffer.sv
// Bench for vga_text_buffer: screen model kept as a 2-D array that scrolls by
// shifting rows; reads are checked through a queue-based scoreboard.
module tb_vga_text_buffer;

    localparam int COLS  = 160;
    localparam int ROWS  = 128;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [14:0] addr_read = '0;
    logic [7:0]  char_read;
    logic [7:0]  char_in = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        clear = 1'b0;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic        busy;

    always #5 clk = ~clk;

    vga_text_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .addr_read  (addr_read),
        .char_read  (char_read),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] scr [ROWS][COLS];
    int         cx, cy;
    logic [7:0] exp_q [$];
    logic       rd_issue = 1'b0;
    logic       rd_vld_d = 1'b0;
    logic [7:0] mon_exp;

    // Read monitor: one result per issued address, one cycle later.
    always @(posedge clk) rd_vld_d <= rd_issue;

    always @(negedge clk) begin
        if (rd_vld_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got=%02h with empty queue", char_read);
            end else begin
                mon_exp = exp_q.pop_front();
                if (char_read !== mon_exp) begin
                    failures++;
                    $display("FAIL char_read got=%02h want=%02h", char_read, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h20;
        cx = 0;
        cy = 0;
    endfunction

    function automatic bit model_newline();
        if (cy < ROWS - 1) begin
            cy++;
            return 1'b0;
        end
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++)
            scr[ROWS-1][c] = 8'h20;
        return 1'b1;
    endfunction

    function automatic bit model_put(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[cy][cx] = b;
            if (cx < COLS - 1) begin
                cx++;
                return 1'b0;
            end
            cx = 0;
            return model_newline();
        end else if (b == 8'h0A) begin
            return model_newline();
        end else if (b == 8'h0D) begin
            cx = 0;
        end else if (b == 8'h08) begin
            if (cx > 0) begin
                cx--;
                scr[cy][cx] = 8'h20;
            end else if (cy > 0) begin
                cx = COLS - 1;
                cy--;
                scr[cy][cx] = 8'h20;
            end
        end
        return 1'b0;
    endfunction

    task automatic send(input logic [7:0] b);
        int k, n;
        bit bad, scrolled;
        k = 0;
        while (!char_ready && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", char_ready, 1);
        char_valid = 1'b1;
        char_in    = b;
        @(posedge clk); #1;
        char_valid = 1'b0;
        scrolled = model_put(b);
        if (scrolled) begin
            n = 0;
            bad = 1'b0;
            while (busy && n < 1000) begin
                if (char_ready) bad = 1'b1;
                @(posedge clk); #1;
                n++;
            end
            chk("scroll_len", n, 160);
            chk("scroll_ready_low", bad, 0);
        end else begin
            chk("busy_after_byte", busy, 0);
        end
        chk("cursor_x", cursor_x, cx);
        chk("cursor_y", cursor_y, cy);
    endtask

    task automatic rd(input int a);
        addr_read = 15'(a);
        rd_issue  = 1'b1;
        exp_q.push_back(scr[a / COLS][a % COLS]);
        @(posedge clk); #1;
        rd_issue = 1'b0;
    endtask

    task automatic drain();
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rd_queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_clear(input int want);
        int n;
        bit bad;
        n = 0;
        bad = 1'b0;
        while (busy && n < 30000) begin
            if (char_ready) bad = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("clear_len", n, want);
        chk("clear_ready_low", bad, 0);
    endtask

    task automatic rand_reads(input int cnt);
        for (int i = 0; i < cnt; i++)
            rd($urandom_range(0, CELLS - 1));
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [7:0] odd [4];
        odd[0] = 8'h00; odd[1] = 8'h7F; odd[2] = 8'h1B; odd[3] = 8'hFF;
        r = $urandom_range(0, 99);
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 80) return 8'h0A;
        if (r < 88) return 8'h0D;
        if (r < 96) return 8'h08;
        return odd[$urandom_range(0, 3)];
    endfunction

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_ready", char_ready, 0);
        chk("rst_char_read", char_read, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        reset = 1'b1;
        wait_clear(CELLS);
        rd(0);
        rd(CELLS - 1);
        rand_reads(64);
        drain();

        send(8'h08);
        rd(0);
        send(8'h41);
        rd(0);
        send(8'h0D);
        drain();

        for (int i = 0; i < COLS; i++) send(8'h42);
        for (int a = 0; a <= COLS; a++) rd(a);
        drain();

        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h51);
        send(8'h08);
        rd(324);
        send(8'h0D);
        send(8'h08);
        rd(319);
        rd(320);
        drain();

        clear      = 1'b1;
        char_valid = 1'b1;
        char_in    = 8'h5A;
        #1;
        chk("clear_blocks_ready", char_ready, 0);
        @(posedge clk); #1;
        clear      = 1'b0;
        char_valid = 1'b0;
        model_clear();
        chk("clear_busy", busy, 1);
        chk("clear_cursor_x", cursor_x, 0);
        chk("clear_cursor_y", cursor_y, 0);
        wait_clear(CELLS);
        rand_reads(32);
        drain();

        for (int i = 0; i < COLS; i++) send(8'h58);
        for (int i = 0; i < ROWS; i++) send(8'h0A);
        rd(0);
        rd(126 * COLS);
        rd(127 * COLS);
        rand_reads(32);
        drain();

        for (int i = 0; i < 400; i++) send(rand_byte());
        rand_reads(200);
        drain();

        while (cy < ROWS - 1) send(8'h0A);
        send(8'h4D);
        while (!char_ready) begin
            @(posedge clk); #1;
        end
        char_valid = 1'b1;
        char_in    = 8'h0A;
        @(posedge clk); #1;
        char_valid = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
        end
        chk("mid_scroll_busy", busy, 1);
        reset = 1'b0;
        #2;
        chk("rst2_busy", busy, 1);
        chk("rst2_ready", char_ready, 0);
        chk("rst2_cursor_x", cursor_x, 0);
        chk("rst2_cursor_y", cursor_y, 0);
        chk("rst2_char_read", char_read, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        wait_clear(CELLS);
        rand_reads(64);
        send(8'h41);
        rd(0);
        rd(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
